// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: external memory bus between the access unit and memory.
// Signals:
//   mem_req   - request, high for every cycle of an access
//   mem_wr    - write qualifier
//   mem_addr  - access address
//   mem_wdata - write data
//   mem_ack   - completion pulse from memory
//   mem_rdata - read data, valid with mem_ack
// Modports: master (access unit side), slave (memory side).
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_wr, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_wr, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: stalls the datapath while one load/store runs on the external memory bus.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   req_addr/req_wdata - address and store data from the datapath
//   req_re/req_we      - load / store request (both high: store, flagged as error)
//   stall              - holds PC and write-back while an access is pending
//   rdata/rdata_valid  - load result, valid during the single response cycle
//   err                - sticky error (conflicting request or memory timeout)
//   access_cnt         - completed accesses, wrapping
//   bus                - external memory bus (master side)
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_re,
  input  logic              req_we,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              err,
  output logic [15:0]       access_cnt,
  mem_access_unit_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  // The counter leaves BUSY on the cycle it would step onto TIMEOUT.
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [7:0]        wcnt;
  logic              start, busy, ack, tmo;
  always_comb begin
    start = (state == IDLE) && (req_re || req_we);
    busy  = state == BUSY;
    ack   = busy && bus.mem_ack;
    tmo   = busy && !bus.mem_ack && (wcnt == LAST);
    nxt   = start ? BUSY : (ack || tmo) ? RESP : (state == RESP) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      wcnt       <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      access_cnt <= '0;
    end else begin
      if (start) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_we;
        wcnt    <= '0;
        if (req_re && req_we) err <= 1'b1;
      end
      if (busy && !bus.mem_ack) wcnt <= wcnt + 8'd1;
      if (ack && !wr_q) rdata <= bus.mem_rdata;
      if (tmo) begin
        rdata <= '0;
        err   <= 1'b1;
      end
      if (ack || tmo) access_cnt <= access_cnt + 16'd1;
    end
  end
  // Bus outputs decode straight from state so an async reset drops them at once.
  assign stall         = start || busy;
  assign rdata_valid   = (state == RESP) && !wr_q;
  assign bus.mem_req   = busy;
  assign bus.mem_wr    = busy && wr_q;
  assign bus.mem_addr  = busy ? addr_q : '0;
  assign bus.mem_wdata = busy ? wdata_q : '0;
endmodule
